pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 192, payload width in bits (six 32-bit fields for a MEM/WB-class stage).
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port stat_clr  input  1  synchronous clear of stall_cnt.
REQ-007 SHALL have port in_valid  input  1  upstream has payload.
REQ-008 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-011 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  head entry payload.
REQ-013 SHALL have port occupancy  output  2  entries held: 0, 1 or 2.
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-015 SHALL be a 2-entry skid buffer: main register (drives out_data) plus skid register; states EMPTY, ONE, FULL.
REQ-016 SHALL define accept = in_valid & in_ready, fire = out_valid & out_ready, both sampled at the rising edge.
REQ-017 SHALL drive in_ready from a register: 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-018 SHALL drive out_valid = 1 in ONE and FULL, 0 in EMPTY; occupancy equals entry count.
REQ-019 EMPTY: accept -> ONE, main <= in_data; otherwise hold.
REQ-020 ONE: accept & fire -> ONE, main <= in_data; accept & !fire -> FULL, skid <= in_data; !accept & fire -> EMPTY; neither -> hold.
REQ-021 FULL: fire -> ONE, main <= skid; !fire -> hold all contents.
REQ-022 SHALL present an entry on out_data exactly one cycle after its accept when the stage was EMPTY (latency 1); order strictly FIFO.
REQ-023 SHALL zero main register on every transition into EMPTY, so out_data = 0 whenever out_valid = 0.
REQ-024 SHALL keep out_data stable while out_valid & !out_ready.
REQ-025 flush SHALL take priority over all handshakes: next state EMPTY, main and skid zeroed, any same-cycle accept discarded, same-cycle fire still counts as consumed downstream.
REQ-026 stall_cnt SHALL increment by 1 each cycle out_valid & !out_ready, saturate at 2^CNT_W-1, never wrap.
REQ-027 stat_clr SHALL set stall_cnt to 0, overriding a same-cycle increment; flush SHALL NOT affect stall_cnt.
REQ-028 SHALL never lose or duplicate an entry across any combination of accept, fire, flush.

Reset
REQ-029 rst_n low SHALL asynchronously force state EMPTY, main = 0, skid = 0, stall_cnt = 0, out_valid = 0, occupancy = 0, in_ready = 0.
REQ-030 in_ready SHALL rise to 1 at the first rising edge after rst_n deasserts; reset mid-transfer discards all entries.

Verification
REQ-031 Streaming: out_ready = 1, in_valid = 1, in_data = 1,2,3,... -> out_data = 1,2,3 one cycle later, occupancy = 1, stall_cnt = 0.
REQ-032 Backpressure: load A, B with out_ready = 0 -> occupancy 2, in_ready 0, out_data = A held; raise out_ready -> A then B, in_ready returns 1 one cycle after first fire.
REQ-033 Flush in FULL with in_valid = 1, in_data = C -> next cycle occupancy 0, out_valid 0, out_data 0, C never appears.
REQ-034 Counter: CNT_W = 3, out_ready = 0 with valid entry for 10 cycles -> stall_cnt = 7; stat_clr pulse during stall -> 0 next cycle.
REQ-035 Async reset asserted mid-cycle in FULL -> outputs zero immediately without clock edge; after release first accepted entry = D appears with occupancy 1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid buffer pipeline stage with registered in_ready and stall counter
module pipe_stage_skid #(
    parameter int WIDTH = 192,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stat_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               accept;
    logic               fire;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    assign accept = in_valid & in_ready_q;
    assign fire   = out_valid & out_ready;

    // The state encoding doubles as the entry count; main is zeroed whenever the stage drains.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (fire) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (stat_clr) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    // in_ready looks only at the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed and randomized bench for pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

    localparam int W  = 192;
    localparam int CW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          stat_clr;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int checks;
    int errors;

    logic [W-1:0] m_q[$];
    logic         m_ready;
    int           m_stall;

    pipe_stage_skid #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .stat_clr  (stat_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return d;
    endfunction

    task automatic check_outputs(input string tag);
        logic [W-1:0] exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : '0;
        chk({tag, ".out_valid"}, W'(out_valid), W'(m_q.size() != 0));
        chk({tag, ".out_data"},  out_data, exp_data);
        chk({tag, ".occupancy"}, W'(occupancy), W'(m_q.size()));
        chk({tag, ".in_ready"},  W'(in_ready), W'(m_ready));
        chk({tag, ".stall_cnt"}, W'(stall_cnt), W'(m_stall));
    endtask

    // Called at posedge+1: drive, check at the falling edge, advance the model, move past the next edge.
    task automatic cycle(input string tag, input logic iv, input logic [W-1:0] id,
                         input logic ordy, input logic fl, input logic clr);
        logic acc;
        logic fir;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        stat_clr  = clr;
        #4;
        check_outputs(tag);
        acc = iv && m_ready;
        fir = (m_q.size() != 0) && ordy;
        if (clr) m_stall = 0;
        else if (m_q.size() != 0 && !ordy && m_stall < CNT_MAX) m_stall++;
        if (fl) begin
            m_q.delete();
        end else begin
            if (fir) void'(m_q.pop_front());
            if (acc) m_q.push_back(id);
        end
        m_ready = (m_q.size() < 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] a, b, c, d;
        checks    = 0;
        errors    = 0;
        m_ready   = 1'b0;
        m_stall   = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        stat_clr  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;
        cycle("release", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        for (int i = 1; i <= 6; i++) cycle("stream", 1'b1, W'(i), 1'b1, 1'b0, 1'b0);
        cycle("stream_tail", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle("stream_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        a = rand_data();
        b = rand_data();
        c = rand_data();
        cycle("bp_load_a", 1'b1, a, 1'b0, 1'b0, 1'b1);
        cycle("bp_load_b", 1'b1, b, 1'b0, 1'b0, 1'b0);
        cycle("bp_full",   1'b1, c, 1'b0, 1'b0, 1'b0);
        chk("bp_full_occ", W'(occupancy), W'(2));
        chk("bp_full_head", out_data, a);
        for (int i = 0; i < 3; i++) cycle("bp_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        cycle("fl_load_a", 1'b1, a, 1'b0, 1'b0, 1'b0);
        cycle("fl_load_b", 1'b1, b, 1'b0, 1'b0, 1'b0);
        cycle("fl_flush",  1'b1, c, 1'b0, 1'b1, 1'b0);
        cycle("fl_after",  1'b0, '0, 1'b1, 1'b0, 1'b0);

        cycle("cnt_clr",  1'b1, a, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle("cnt_stall", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("cnt_saturated", W'(stall_cnt), W'(CNT_MAX));
        cycle("cnt_flush_keeps", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle("cnt_after_flush", 1'b1, b, 1'b0, 1'b0, 1'b0);
        cycle("cnt_clr_pulse",   1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle("cnt_after_clr",   1'b0, '0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 3) != 0),
                  rand_data(),
                  1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 29) == 0));
        end

        cycle("ar_load_a", 1'b1, a, 1'b0, 1'b1, 1'b1);
        cycle("ar_load_b", 1'b1, b, 1'b0, 1'b0, 1'b0);
        cycle("ar_load_c", 1'b1, c, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        m_q.delete();
        m_ready = 1'b0;
        m_stall = 0;
        chk("ar_out_valid", W'(out_valid), '0);
        chk("ar_out_data",  out_data, '0);
        chk("ar_occupancy", W'(occupancy), '0);
        chk("ar_in_ready",  W'(in_ready), '0);
        chk("ar_stall_cnt", W'(stall_cnt), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        d = rand_data();
        cycle("ar_release", 1'b1, d, 1'b1, 1'b0, 1'b0);
        cycle("ar_load_d",  1'b1, d, 1'b0, 1'b0, 1'b0);
        chk("ar_d_occ",  W'(occupancy), W'(1));
        chk("ar_d_data", out_data, d);
        cycle("ar_final", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
